// File: rtl/clamp_pkg.sv
// Shared clamp mode encodings for the clamp-share arbiter and its datapath.
package clamp_pkg;

    typedef logic [1:0] clamp_mode_t;

    localparam clamp_mode_t CLAMP_SRANGE = 2'b00;  // signed -> signed OUTW range
    localparam clamp_mode_t CLAMP_SPOS   = 2'b01;  // signed -> [0, 2^OUTW-1]
    localparam clamp_mode_t CLAMP_UPOS   = 2'b10;  // unsigned -> [0, 2^OUTW-1]
    localparam clamp_mode_t CLAMP_TRUNC  = 2'b11;  // keep low OUTW bits, never saturates

endpackage

// File: rtl/clampSPositive.sv
// Signed operand clamped to the unsigned OUTW-bit range; negatives go to 0.
module clampSPositive #(
    parameter int INW  = 16,
    parameter int OUTW = 8
) (
    input  logic [INW-1:0]  value,
    output logic [OUTW-1:0] result,
    output logic            sat
);

    logic neg;
    logic over;

    assign neg  = value[INW-1];
    assign over = |(value >> OUTW);

    // Negative wins over the overflow test (a negative also has high bits set).
    always_comb begin
        result = value[OUTW-1:0];
        sat    = neg | over;
        if (neg)
            result = '0;
        else if (over)
            result = '1;
    end

endmodule

// File: rtl/clampSRange.sv
// Signed operand clamped to the signed OUTW-bit range.
module clampSRange #(
    parameter int INW  = 16,
    parameter int OUTW = 8
) (
    input  logic [INW-1:0]  value,
    output logic [OUTW-1:0] result,
    output logic            sat
);

    // In range when every bit from OUTW-1 upward matches the sign.
    logic [INW-1:0] hi;
    logic           in_range;

    assign hi       = value >> (OUTW - 1);
    assign in_range = (hi == '0) || (hi == ({INW{1'b1}} >> (OUTW - 1)));

    // Pass through when representable, otherwise pin to the nearest rail.
    always_comb begin
        result = value[OUTW-1:0];
        sat    = 1'b0;
        if (!in_range) begin
            sat    = 1'b1;
            result = value[INW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/clampUPositive.sv
// Unsigned operand clamped to the unsigned OUTW-bit range.
module clampUPositive #(
    parameter int INW  = 16,
    parameter int OUTW = 8
) (
    input  logic [INW-1:0]  value,
    output logic [OUTW-1:0] result,
    output logic            sat
);

    logic over;

    assign over = |(value >> OUTW);

    // Any set bit above OUTW saturates to all ones.
    always_comb begin
        result = value[OUTW-1:0];
        sat    = over;
        if (over)
            result = '1;
    end

endmodule

// File: rtl/clamp_mode_unit.sv
// Combinational clamp datapath: all clamp flavours evaluated, mode selects one.
module clamp_mode_unit
    import clamp_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 8
) (
    input  logic [INW-1:0]  value,
    input  clamp_mode_t     mode,
    output logic [OUTW-1:0] result,
    output logic            sat
);

    logic [OUTW-1:0] sr_res, sp_res, up_res;
    logic            sr_sat, sp_sat, up_sat;

    clampSRange #(.INW(INW), .OUTW(OUTW)) u_srange (
        .value (value),
        .result(sr_res),
        .sat   (sr_sat)
    );

    clampSPositive #(.INW(INW), .OUTW(OUTW)) u_spos (
        .value (value),
        .result(sp_res),
        .sat   (sp_sat)
    );

    clampUPositive #(.INW(INW), .OUTW(OUTW)) u_upos (
        .value (value),
        .result(up_res),
        .sat   (up_sat)
    );

    // Mode select; truncate is just the low bits and never flags saturation.
    always_comb begin
        result = value[OUTW-1:0];
        sat    = 1'b0;
        case (mode)
            CLAMP_SRANGE: begin result = sr_res; sat = sr_sat; end
            CLAMP_SPOS:   begin result = sp_res; sat = sp_sat; end
            CLAMP_UPOS:   begin result = up_res; sat = up_sat; end
            default:      begin result = value[OUTW-1:0]; sat = 1'b0; end
        endcase
    end

endmodule

// File: rtl/clamp_share_arbiter.sv
// Round-robin arbiter sharing one clamp datapath among NREQ requesters,
// followed by a 2-stage pipeline (s1 = operand, s2 = clamped result).
// Optional saturation counter enabled by defining CLAMP_ARB_STATS_EN.
module clamp_share_arbiter
    import clamp_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int INW  = 16,
    parameter  int OUTW = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*INW-1:0]  req_value,
    input  logic [NREQ*2-1:0]    req_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUTW-1:0]      out_value,
    output logic [IDW-1:0]       out_id,
    output logic                 out_sat
`ifdef CLAMP_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [15:0]          sat_count
`endif
);

    logic [IDW-1:0]  rr_ptr;
    logic            s1_valid;
    logic [INW-1:0]  s1_value;
    clamp_mode_t     s1_mode;
    logic [IDW-1:0]  s1_id;

    logic            s1_adv, s2_adv;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  scan_idx;
    logic [INW-1:0]  gnt_value;
    clamp_mode_t     gnt_mode;

    logic [OUTW-1:0] clamp_result;
    logic            clamp_sat;

    // s2 is the output register, so its valid is out_valid.
    assign s2_adv = !out_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Scan from rr_ptr upward (mod NREQ); only grant when s1 can take the word.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (s1_adv) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
                if (!gnt_any && req_valid[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
    end

    // One-hot accept for the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = gnt_any && (gnt_idx == IDW'(i));
    end

    // Operand and mode of the winner.
    always_comb begin
        gnt_value = req_value[int'(gnt_idx)*INW +: INW];
        gnt_mode  = clamp_mode_t'(req_mode[int'(gnt_idx)*2 +: 2]);
    end

    // Stage 1: capture the granted request and move the round-robin pointer past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_value <= '0;
            s1_mode  <= CLAMP_SRANGE;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (s1_adv) begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                s1_value <= gnt_value;
                s1_mode  <= gnt_mode;
                s1_id    <= gnt_idx;
                rr_ptr   <= IDW'((int'(gnt_idx) + 1) % NREQ);
            end
        end
    end

    clamp_mode_unit #(.INW(INW), .OUTW(OUTW)) u_clamp (
        .value (s1_value),
        .mode  (s1_mode),
        .result(clamp_result),
        .sat   (clamp_sat)
    );

    // Stage 2: register the clamp result; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_value <= clamp_result;
                out_id    <= s1_id;
                out_sat   <= clamp_sat;
            end
        end
    end

`ifdef CLAMP_ARB_STATS_EN
    // Saturation event counter: clear beats increment, sticks at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (stats_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_clamp_share_arbiter.sv
// Scoreboard bench for clamp_share_arbiter: expectations pushed at request
// handshake, popped and compared by an independent output monitor.
module tb_clamp_share_arbiter;

    localparam int NREQ = 4;
    localparam int INW  = 16;
    localparam int OUTW = 8;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*INW-1:0] req_value;
    logic [NREQ*2-1:0]   req_mode;
    logic                out_valid;
    logic                out_ready;
    logic [OUTW-1:0]     out_value;
    logic [IDW-1:0]      out_id;
    logic                out_sat;
`ifdef CLAMP_ARB_STATS_EN
    logic                stats_clr;
    logic [15:0]         sat_count;
`endif

    clamp_share_arbiter #(.NREQ(NREQ), .INW(INW), .OUTW(OUTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_value(req_value),
        .req_mode (req_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_id   (out_id),
        .out_sat  (out_sat)
`ifdef CLAMP_ARB_STATS_EN
        ,
        .stats_clr(stats_clr),
        .sat_count(sat_count)
`endif
    );

    typedef struct {
        logic [OUTW-1:0] v;
        logic [IDW-1:0]  id;
        logic            sat;
    } exp_t;

    exp_t            sb[$];
    int              grant_log[$];
    logic [OUTW-1:0] exp_v[NREQ];
    logic            exp_s[NREQ];
    int              total = 0;
    int              bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    // Handshake collector: push the hand-computed expectation of each accepted request.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid != '0)
                chk("ready_onehot", {31'd0, $countones(req_ready) <= 1}, 1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{v: exp_v[i], id: IDW'(i), sat: exp_s[i]});
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Output monitor: every delivered result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_id), 32'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_value", 32'(out_value), 32'(e.v));
                chk("out_id",    32'(out_id),    32'(e.id));
                chk("out_sat",   32'(out_sat),   32'(e.sat));
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] v, input logic [1:0] m,
                           input logic [7:0] ev, input logic es);
        req_value[i*INW +: INW] = v;
        req_mode[i*2 +: 2]      = m;
        exp_v[i]                = ev;
        exp_s[i]                = es;
    endtask

    // Present one request (called just after a rising edge) and hold it until accepted.
    task automatic send(input int i, input logic [15:0] v, input logic [1:0] m,
                        input logic [7:0] ev, input logic es);
        bit got = 0;
        set_req(i, v, m, ev, es);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", {31'd0, done}, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t snap;
        bit   have;
        int   ok;

        rst       = 1'b1;
        req_valid = '0;
        req_value = '0;
        req_mode  = '0;
        out_ready = 1'b1;
`ifdef CLAMP_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin exp_v[i] = '0; exp_s[i] = 1'b0; end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_value", 32'(out_value), 0);
        chk("rst_out_id",    32'(out_id),    0);
        chk("rst_out_sat",   32'(out_sat),   0);
`ifdef CLAMP_ARB_STATS_EN
        chk("rst_sat_count", 32'(sat_count), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Clamp modes, boundary values included.
        send(0, 16'h012C, 2'b00, 8'h7F, 1'b1);  // +300 SRANGE
        send(1, 16'hFED4, 2'b00, 8'h80, 1'b1);  // -300 SRANGE
        send(2, 16'h0005, 2'b00, 8'h05, 1'b0);  // +5 SRANGE
        send(3, 16'hFFFF, 2'b01, 8'h00, 1'b1);  // -1 SPOS
        send(0, 16'h0100, 2'b10, 8'hFF, 1'b1);  // 256 UPOS
        send(1, 16'h1234, 2'b11, 8'h34, 1'b0);  // TRUNC
        send(2, 16'h00C8, 2'b01, 8'hC8, 1'b0);  // 200 SPOS in range
        send(3, 16'hFF80, 2'b00, 8'h80, 1'b0);  // -128 SRANGE edge
        send(0, 16'h0080, 2'b00, 8'h7F, 1'b1);  // +128 SRANGE just over
        send(1, 16'h00FF, 2'b10, 8'hFF, 1'b0);  // 255 UPOS edge
        send(2, 16'h8000, 2'b10, 8'hFF, 1'b1);  // 0x8000 UPOS is large, not negative
        send(3, 16'hFF7F, 2'b00, 8'h80, 1'b1);  // -129 SRANGE just under
        drain();

        // Latency: accepted at N, visible at N+2.
        set_req(0, 16'h00AA, 2'b11, 8'hAA, 1'b0);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("lat_accept", 32'(req_ready[0]), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(out_valid), 1);
        drain();

        // Requesters 0 and 2 always valid: strict alternation, one grant per cycle.
        set_req(0, 16'h00AB, 2'b11, 8'hAB, 1'b0);
        set_req(2, 16'h2277, 2'b11, 8'h77, 1'b0);
        grant_log.delete();
        req_valid = 4'b0101;
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr_grant_count", 32'(grant_log.size()), 8);
        ok = 1;
        for (int k = 0; k < grant_log.size(); k++) begin
            if (grant_log[k] != 0 && grant_log[k] != 2) ok = 0;
            if (k > 0 && grant_log[k] == grant_log[k-1]) ok = 0;
        end
        chk("rr_alternate", 32'(ok), 1);
        drain();

        // Backpressure: 5 stalled cycles with everyone valid.
        set_req(0, 16'h012C, 2'b00, 8'h7F, 1'b1);
        set_req(1, 16'hFFFF, 2'b01, 8'h00, 1'b1);
        set_req(2, 16'h0100, 2'b10, 8'hFF, 1'b1);
        set_req(3, 16'h1234, 2'b11, 8'h34, 1'b0);
        grant_log.delete();
        out_ready = 1'b0;
        req_valid = 4'hF;
        have = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) begin
                if (!have) begin
                    snap = '{v: out_value, id: out_id, sat: out_sat};
                    have = 1;
                end else begin
                    chk("stall_value", 32'(out_value), 32'(snap.v));
                    chk("stall_id",    32'(out_id),    32'(snap.id));
                    chk("stall_sat",   32'(out_sat),   32'(snap.sat));
                end
            end
        end
        chk("stall_accepts", 32'(grant_log.size()), 2);
        chk("stall_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        drain();

`ifdef CLAMP_ARB_STATS_EN
        // Counter: three saturations counted, clear wins over a same-cycle event.
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_cleared", 32'(sat_count), 0);
        @(posedge clk); #1;
        send(0, 16'h012C, 2'b00, 8'h7F, 1'b1);
        send(1, 16'hFFFF, 2'b01, 8'h00, 1'b1);
        send(2, 16'h1234, 2'b11, 8'h34, 1'b0);
        send(3, 16'h0100, 2'b10, 8'hFF, 1'b1);
        drain();
        chk("stats_three", 32'(sat_count), 3);
        out_ready = 1'b0;
        send(0, 16'hFED4, 2'b00, 8'h80, 1'b1);
        have = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin have = 1; break; end
        end
        chk("stats_staged", 32'(have), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clear_wins", 32'(sat_count), 0);
        drain();
`endif

        // Reset with both stages full, then first grant must go to requester 0.
        out_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("pre_rst_full", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_value", 32'(out_value), 0);
        chk("midrst_out_id",    32'(out_id),    0);
        chk("midrst_out_sat",   32'(out_sat),   0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
